axi_multi_port_lock: RTL
========================

// Module: axi_multi_port_lock
// PURPOSE
//  N-channel generalisation of the AXI4 write/read mutual-exclusion lock.
//  Arbitrates exclusive access to one shared AXI4 port among NCH requesters (VDMA write/read engines).
//  Only one channel executes at a time; every other channel is held off via its pend bit.
//  Adds selectable fair round-robin or fixed priority, an optional hold-time watchdog, and owner reporting.
// PARAMETERS
//  NCH       2  number of requesting channels (>=2)
//  RR_MODE   1  1: round-robin after each release; 0: fixed priority, lowest index wins
//  HOLD_MAX  0  max cycles one grant may be held; 0 disables watchdog
//  OW        $clog2(NCH)  owner index width (localparam, not overridable)
// PORTS
//  clock     in   1    single clock, rising edge
//  rst_n     in   1    asynchronous active-low reset
//  req       in   NCH  level request per channel
//  done      in   NCH  one-cycle end-of-transaction strobe per channel
//  grant     out  NCH  one-hot execute permission, registered
//  pend      out  NCH  hold-off per channel, registered
//  busy      out  1    a grant is active
//  owner     out  OW   index of granted channel; valid only while busy
//  timeout   out  1    one-cycle pulse: watchdog forced a release
// BEHAVIOUR
//  Reset (async): grant=0, pend=0, busy=0, owner=0, timeout=0, cnt=0, last=NCH-1, state=IDLE.
//  FSM, 2 states:
//   IDLE: if any req -> EXEC, owner=pick(req,last); else stay IDLE.
//   EXEC: owner's done=1 -> IDLE (last=owner).
//         HOLD_MAX>0 && cnt==HOLD_MAX-1 && !done[owner] -> IDLE (last=owner), timeout.
//         otherwise stay EXEC.
//  Outputs are registered from next state: req sampled high at edge t gives grant at t+1 (1-cycle latency).
//  EXEC: grant[owner]=1, pend[j]=1 for all j!=owner, busy=1.
//  IDLE: grant=0, pend=0, busy=0.
//  Handover: always exactly one IDLE cycle with all grants low. done at edge t -> grant drops at t+1.
//   Next owner is granted at t+2 if a req is high at t+1.
//  pick: RR_MODE=1 searches last+1, last+2 .. last+NCH (mod NCH) and takes the first req set.
//   RR_MODE=0 takes the lowest set index.
//   With NCH=2 and RR_MODE=1 this reproduces the write-then-read-preference alternation.
//  done from non-owners, and any done in IDLE: ignored.
//  req is not re-checked in EXEC; dropping req does not release; only done or the watchdog releases.
//  Watchdog cnt (width $clog2(HOLD_MAX+1)): 0 on the first EXEC cycle, +1 each EXEC cycle.
//   Forced release holds grant exactly HOLD_MAX cycles.
//   timeout=1 only in the first IDLE cycle after a forced release; done and limit in the same cycle count as a normal release (no timeout).
//  Reset mid-EXEC: all outputs clear immediately (async); no done is required afterwards.
//  owner holds its last value while IDLE.
// STRUCTURE
//  axi_lock_pkg: typedef enum logic {LK_IDLE, LK_EXEC} lock_st_e; function rr_next(last, NCH).
//  Sub-module rr_pick #(NCH): combinational; inputs req, last, mode; outputs idx, valid.
//  Top level: FSM, last/cnt registers, output registers.
// TESTING
//  1 Reset: drive req=2'b11 during reset -> grant=0, pend=0, busy=0; after release, first grant goes to ch0.
//  2 NCH=2 RR: req=11, pulse each done after 3 grant cycles -> grant 01,00,10,00,01; pend mirrors the other bit.
//  3 NCH=4 RR_MODE=0: req=1010, done each 2 cycles -> ch1 is granted every time; ch3 never is (starvation by design).
//  4 NCH=4 RR: req=1111 -> owner sequence 0,1,2,3,0; one idle cycle between grants.
//  5 HOLD_MAX=5, no done -> grant high exactly 5 cycles, then timeout pulse 1 cycle, next channel granted.
//  6 done on non-owner ch, then rst_n low mid-EXEC -> no release on the wrong done; all outputs 0 within reset; restart grants ch0.

Source files
------------

// File: rtl/axi_lock_pkg.sv
// Shared types and helpers for the multi-channel AXI access lock.
package axi_lock_pkg;

  typedef enum logic {
    LK_IDLE = 1'b0,
    LK_EXEC = 1'b1
  } lock_st_e;

  // Next channel index after 'last', wrapping at nch.
  function automatic int rr_next(input int last, input int nch);
    return (last + 1 >= nch) ? 0 : last + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational requester selection: round-robin starting after 'last',
// or fixed priority with the lowest index winning.
module rr_pick
  import axi_lock_pkg::*;
#(
  parameter int  NCH = 2,
  localparam int OW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [OW-1:0]  last,
  input  logic           mode,
  output logic [OW-1:0]  idx,
  output logic           valid
);

  logic [OW-1:0] cand;

  // Walk the channels in search order and take the first one requesting.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    cand  = mode ? OW'(rr_next(int'(last), NCH)) : '0;
    for (int k = 0; k < NCH; k++) begin
      if (!valid && req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
      cand = OW'(rr_next(int'(cand), NCH));
    end
  end

endmodule

// File: rtl/axi_multi_port_lock.sv
// Mutual-exclusion lock granting one of NCH requesters access to a shared
// AXI4 port. One idle cycle separates every handover; an optional watchdog
// forces release after HOLD_MAX cycles of ownership.
module axi_multi_port_lock
  import axi_lock_pkg::*;
#(
  parameter int  NCH      = 2,
  parameter bit  RR_MODE  = 1'b1,
  parameter int  HOLD_MAX = 0,
  localparam int OW       = $clog2(NCH)
) (
  input  logic           clock,
  input  logic           rst_n,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] done,
  output logic [NCH-1:0] grant,
  output logic [NCH-1:0] pend,
  output logic           busy,
  output logic [OW-1:0]  owner,
  output logic           timeout
);

  // Counter is kept one bit wide when the watchdog is disabled.
  localparam int            CW      = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_LIM = CW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

  lock_st_e       state_q, state_d;
  logic [OW-1:0]  owner_q, owner_d;
  logic [OW-1:0]  last_q, last_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [NCH-1:0] grant_q, grant_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic           busy_q, busy_d;
  logic           timeout_q, timeout_d;
  logic [OW-1:0]  pick_idx;
  logic           pick_vld;

  rr_pick #(.NCH(NCH)) u_pick (
    .req   (req),
    .last  (last_q),
    .mode  (RR_MODE),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  // Next-state logic: grant on any request, release on owner done or watchdog.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      LK_IDLE: begin
        if (pick_vld) begin
          state_d = LK_EXEC;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      LK_EXEC: begin
        // Done wins over the limit, so a coincident done is a normal release.
        if (done[owner_q]) begin
          state_d = LK_IDLE;
          last_d  = owner_q;
        end else if ((HOLD_MAX > 0) && (cnt_q == CNT_LIM)) begin
          state_d   = LK_IDLE;
          last_d    = owner_q;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = LK_IDLE;
    endcase
  end

  // Output values derived from the next state so they register with it.
  always_comb begin
    grant_d = '0;
    pend_d  = '0;
    busy_d  = 1'b0;
    if (state_d == LK_EXEC) begin
      grant_d = NCH'(1) << owner_d;
      pend_d  = ~(NCH'(1) << owner_d);
      busy_d  = 1'b1;
    end
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LK_IDLE;
      owner_q   <= '0;
      last_q    <= OW'(NCH - 1);
      cnt_q     <= '0;
      grant_q   <= '0;
      pend_q    <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      pend_q    <= pend_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant   = grant_q;
  assign pend    = pend_q;
  assign busy    = busy_q;
  assign owner   = owner_q;
  assign timeout = timeout_q;

endmodule
